// File: rtl/eth_ff_pkg.sv
// Shared types and beat builders for the Ethernet frame former.
// The state encoding is visible on state_dbg, so its values are fixed.
package eth_ff_pkg;

    typedef enum logic [2:0] {
        StIdle    = 3'd0,
        StHdr1    = 3'd1,
        StSeq     = 3'd2,
        StPayload = 3'd3,
        StPad     = 3'd4,
        StTrailer = 3'd5
    } state_e;

    localparam int unsigned MIN_BODY_SEQ   = 5;
    localparam int unsigned MIN_BODY_NOSEQ = 6;

    localparam logic [7:0] KEEP_FULL    = 8'hFF;
    localparam logic [7:0] KEEP_TRAILER = 8'h03;

    function automatic logic [63:0] build_beat0(input logic [47:0] dest,
                                                input logic [15:0] src_lo);
        return {src_lo, dest};
    endfunction

    function automatic logic [63:0] build_beat1(input logic [15:0] sync,
                                                input logic [15:0] ltype,
                                                input logic [31:0] src_hi);
        return {sync, ltype, src_hi};
    endfunction

    function automatic logic [63:0] build_seq_beat(input logic [15:0] len,
                                                   input logic [31:0] seq);
        return {16'h0, len, seq};
    endfunction

endpackage

// File: rtl/eth_frame_former_v2_axis_out_reg.sv
// AXI4-Stream output register: loads only when empty or being drained,
// holds data/keep/last stable while stalled.
module axis_out_reg #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned KEEP_W = 8
) (
    input  logic              ACLK,
    input  logic              ARESETN,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic [KEEP_W-1:0] i_keep,
    input  logic              i_last,
    input  logic              i_ready,
    output logic              o_free,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data,
    output logic [KEEP_W-1:0] o_keep,
    output logic              o_last
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;
    logic [KEEP_W-1:0] r_keep;
    logic              r_last;

    assign o_free  = !r_valid || i_ready;
    assign o_valid = r_valid;
    assign o_data  = r_data;
    assign o_keep  = r_keep;
    assign o_last  = r_last;

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
            r_last  <= 1'b0;
        end else if (o_free) begin
            r_valid <= i_load;
            r_last  <= i_load && i_last;
            if (i_load) begin
                r_data <= i_data;
                r_keep <= i_keep;
            end
        end
    end

endmodule

// File: rtl/eth_frame_former_v2.sv
// Builds header, optional sequence beat, payload, zero padding and trailer
// into complete Ethernet frames on an AXI4-Stream manager port.
module eth_frame_former_v2
    import eth_ff_pkg::*;
#(
    parameter int unsigned MAX_PAYLOAD_BEATS = 1024,
    parameter bit          SEQ_EN            = 1'b1,
    parameter logic [15:0] TRAILER_WORD      = 16'h5704,
    parameter int unsigned LEN_W             = $clog2(MAX_PAYLOAD_BEATS + 1)
) (
    input  logic             ACLK,
    input  logic             ARESETN,
    input  logic             enable,
    input  logic [47:0]      dest_addr,
    input  logic [47:0]      src_addr,
    input  logic [15:0]      link_type,
    input  logic [15:0]      sync_word,
    input  logic [LEN_W-1:0] payload_beats,
    input  logic [63:0]      s_axis_tdata,
    input  logic             s_axis_tvalid,
    output logic             s_axis_tready,
    output logic [63:0]      m_axis_tdata,
    output logic [7:0]       m_axis_tkeep,
    output logic             m_axis_tvalid,
    input  logic             m_axis_tready,
    output logic             m_axis_tlast,
    output logic [31:0]      seq_num,
    output logic             busy,
    output logic [2:0]       state_dbg
);

    localparam int unsigned      MIN_BODY   = SEQ_EN ? MIN_BODY_SEQ : MIN_BODY_NOSEQ;
    localparam logic [LEN_W-1:0] MAX_LEN    = LEN_W'(MAX_PAYLOAD_BEATS);
    localparam logic [LEN_W-1:0] MIN_BODY_L = LEN_W'(MIN_BODY);

    state_e           r_state;
    state_e           w_state_next;
    logic [47:0]      r_dest;
    logic [31:0]      r_src_hi;
    logic [15:0]      r_type;
    logic [15:0]      r_sync;
    logic [LEN_W-1:0] r_len;
    logic [LEN_W-1:0] r_cnt;
    logic [2:0]       r_pad;
    logic [31:0]      r_seq;
    logic             r_busy;

    logic             w_free;
    logic             w_start;
    logic             w_load;
    logic [63:0]      w_data;
    logic [7:0]       w_keep;
    logic             w_last;
    logic             w_s_ready;
    logic             w_in_hs;
    logic             w_last_hs;
    logic [LEN_W-1:0] w_len;
    logic [2:0]       w_pad_start;

    assign w_len       = (payload_beats > MAX_LEN) ? MAX_LEN : payload_beats;
    assign w_pad_start = (w_len < MIN_BODY_L) ? 3'(MIN_BODY_L - w_len) : 3'd0;
    assign w_start     = (r_state == StIdle) && enable && s_axis_tvalid &&
                         (payload_beats != '0) && w_free;
    assign w_in_hs     = w_s_ready && s_axis_tvalid;
    assign w_last_hs   = m_axis_tvalid && m_axis_tready && m_axis_tlast;

    always_comb begin
        w_state_next = r_state;
        w_load       = 1'b0;
        w_data       = '0;
        w_keep       = '0;
        w_last       = 1'b0;
        w_s_ready    = 1'b0;
        unique case (r_state)
            StIdle: begin
                // Beat0 comes straight from the ports: config latches on this same edge.
                if (w_start) begin
                    w_load       = 1'b1;
                    w_data       = build_beat0(dest_addr, src_addr[15:0]);
                    w_keep       = KEEP_FULL;
                    w_state_next = StHdr1;
                end
            end
            StHdr1: begin
                if (w_free) begin
                    w_load       = 1'b1;
                    w_data       = build_beat1(r_sync, r_type, r_src_hi);
                    w_keep       = KEEP_FULL;
                    w_state_next = SEQ_EN ? StSeq : StPayload;
                end
            end
            StSeq: begin
                if (w_free) begin
                    w_load       = 1'b1;
                    w_data       = build_seq_beat(16'(r_len), r_seq);
                    w_keep       = KEEP_FULL;
                    w_state_next = StPayload;
                end
            end
            StPayload: begin
                w_s_ready = w_free;
                if (w_in_hs) begin
                    w_load = 1'b1;
                    w_data = s_axis_tdata;
                    w_keep = KEEP_FULL;
                    if (r_cnt == r_len - 1'b1) begin
                        w_state_next = (r_pad != 3'd0) ? StPad : StTrailer;
                    end
                end
            end
            StPad: begin
                if (w_free) begin
                    w_load = 1'b1;
                    w_keep = KEEP_FULL;
                    if (r_pad == 3'd1) begin
                        w_state_next = StTrailer;
                    end
                end
            end
            StTrailer: begin
                if (w_free) begin
                    w_load       = 1'b1;
                    w_data       = {48'h0, TRAILER_WORD};
                    w_keep       = KEEP_TRAILER;
                    w_last       = 1'b1;
                    w_state_next = StIdle;
                end
            end
            default: w_state_next = StIdle;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_state  <= StIdle;
            r_dest   <= '0;
            r_src_hi <= '0;
            r_type   <= '0;
            r_sync   <= '0;
            r_len    <= '0;
            r_cnt    <= '0;
            r_pad    <= '0;
            r_seq    <= '0;
            r_busy   <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_start) begin
                r_dest   <= dest_addr;
                r_src_hi <= src_addr[47:16];
                r_type   <= link_type;
                r_sync   <= sync_word;
                r_len    <= w_len;
                r_pad    <= w_pad_start;
                r_cnt    <= '0;
            end
            if (w_in_hs) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (r_state == StPad && w_free) begin
                r_pad <= r_pad - 3'd1;
            end
            if (w_last_hs) begin
                r_seq  <= r_seq + 32'd1;
                r_busy <= 1'b0;
            end
            // A start on the trailer handshake edge keeps busy asserted.
            if (w_start) begin
                r_busy <= 1'b1;
            end
        end
    end

    axis_out_reg #(
        .DATA_W(64),
        .KEEP_W(8)
    ) u_out_reg (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .i_load  (w_load),
        .i_data  (w_data),
        .i_keep  (w_keep),
        .i_last  (w_last),
        .i_ready (m_axis_tready),
        .o_free  (w_free),
        .o_valid (m_axis_tvalid),
        .o_data  (m_axis_tdata),
        .o_keep  (m_axis_tkeep),
        .o_last  (m_axis_tlast)
    );

    assign s_axis_tready = w_s_ready;
    assign seq_num       = r_seq;
    assign busy          = r_busy;
    assign state_dbg     = r_state;

endmodule

// File: tb/tb_eth_frame_former_v2.sv
// Scoreboard bench for eth_frame_former_v2: expected beats are queued as
// stimulus is generated and popped on every output handshake.
module tb_eth_frame_former_v2;

    localparam int unsigned MAXB = 1024;
    localparam int unsigned LW   = 11;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } beat_t;

    logic          ACLK = 1'b0;
    logic          ARESETN = 1'b0;
    logic          enable = 1'b0;
    logic [47:0]   dest_addr = '0;
    logic [47:0]   src_addr = '0;
    logic [15:0]   link_type = '0;
    logic [15:0]   sync_word = '0;
    logic [LW-1:0] payload_beats = '0;
    logic [63:0]   s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic [63:0]   m_axis_tdata;
    logic [7:0]    m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b1;
    logic          m_axis_tlast;
    logic [31:0]   seq_num;
    logic          busy;
    logic [2:0]    state_dbg;

    beat_t       exp_q[$];
    logic [63:0] in_q[$];
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned n_out = 0;
    logic [31:0] exp_seq = '0;
    bit          mon_en = 1'b0;
    bit          gap_mode = 1'b0;
    bit          rand_ready = 1'b0;
    bit          btb_mode = 1'b0;

    always #5 ACLK = ~ACLK;

    eth_frame_former_v2 dut (
        .ACLK          (ACLK),
        .ARESETN       (ARESETN),
        .enable        (enable),
        .dest_addr     (dest_addr),
        .src_addr      (src_addr),
        .link_type     (link_type),
        .sync_word     (sync_word),
        .payload_beats (payload_beats),
        .s_axis_tdata  (s_axis_tdata),
        .s_axis_tvalid (s_axis_tvalid),
        .s_axis_tready (s_axis_tready),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tkeep  (m_axis_tkeep),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .seq_num       (seq_num),
        .busy          (busy),
        .state_dbg     (state_dbg)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic exp_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
        beat_t b;
        b.data = d;
        b.keep = k;
        b.last = l;
        exp_q.push_back(b);
    endtask

    // Reference frame model, built from the current config inputs.
    task automatic push_frame(input int unsigned lreq);
        int unsigned l;
        int unsigned pad;
        logic [63:0] w;
        l   = (lreq > MAXB) ? MAXB : lreq;
        pad = (l < 5) ? 5 - l : 0;
        exp_beat({src_addr[15:0], dest_addr}, 8'hFF, 1'b0);
        exp_beat({sync_word, link_type, src_addr[47:16]}, 8'hFF, 1'b0);
        exp_beat({16'h0, 16'(l), exp_seq}, 8'hFF, 1'b0);
        for (int i = 0; i < int'(l); i++) begin
            w = {$urandom, $urandom};
            in_q.push_back(w);
            exp_beat(w, 8'hFF, 1'b0);
        end
        for (int i = 0; i < int'(pad); i++) exp_beat(64'h0, 8'hFF, 1'b0);
        exp_beat(64'h0000_0000_0000_5704, 8'h03, 1'b1);
        exp_seq = exp_seq + 32'd1;
    endtask

    // Scenario-1 frame with literal expected beats (seq 0, L = 8).
    task automatic push_s1();
        dest_addr     = 48'h0A0B0C0D0E0F;
        src_addr      = 48'h112233445566;
        link_type     = 16'h88B5;
        sync_word     = 16'hA5A5;
        payload_beats = LW'(8);
        exp_beat(64'h55660A0B0C0D0E0F, 8'hFF, 1'b0);
        exp_beat(64'hA5A588B511223344, 8'hFF, 1'b0);
        exp_beat(64'h0000000800000000, 8'hFF, 1'b0);
        for (int i = 0; i < 8; i++) begin
            in_q.push_back(64'hC0DE_0000_0000_0000 | 64'(i));
            exp_beat(64'hC0DE_0000_0000_0000 | 64'(i), 8'hFF, 1'b0);
        end
        exp_beat(64'h0000_0000_0000_5704, 8'h03, 1'b1);
        exp_seq = exp_seq + 32'd1;
    endtask

    task automatic tick();
        @(posedge ACLK);
        #2;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        check_eq({tag, "_drained"}, 64'(exp_q.size()), 64'd0);
        tick();
        tick();
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_seq"}, 64'(seq_num), 64'(exp_seq));
    endtask

    task automatic do_reset(input string tag);
        mon_en  = 1'b0;
        ARESETN = 1'b0;
        in_q.delete();
        exp_q.delete();
        exp_seq = '0;
        tick();
        check_eq({tag, "_tvalid"}, 64'(m_axis_tvalid), 64'd0);
        check_eq({tag, "_s_tready"}, 64'(s_axis_tready), 64'd0);
        check_eq({tag, "_seq"}, 64'(seq_num), 64'd0);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        ARESETN = 1'b1;
        mon_en  = 1'b1;
    endtask

    // Input driver and tready generator; changes land 1 time unit after the edge.
    initial begin : drive
        int unsigned cyc = 0;
        logic hs;
        forever begin
            @(negedge ACLK);
            hs = s_axis_tvalid && s_axis_tready;
            @(posedge ACLK);
            #1;
            if (hs && in_q.size() > 0) void'(in_q.pop_front());
            cyc++;
            s_axis_tvalid = (in_q.size() > 0) && !(gap_mode && (cyc % 3 == 0));
            s_axis_tdata  = (in_q.size() > 0) ? in_q[0] : 64'h0;
            m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    // Output monitor: scoreboard pops, stall-hold and back-to-back checks.
    initial begin : monitor
        bit          stalled = 1'b0;
        bit          after_last = 1'b0;
        beat_t       held;
        beat_t       e;
        forever begin
            @(negedge ACLK);
            if (!mon_en) begin
                stalled    = 1'b0;
                after_last = 1'b0;
            end else begin
                if (stalled) begin
                    check_eq("hold_data", m_axis_tdata, held.data);
                    check_eq("hold_keep", 64'(m_axis_tkeep), 64'(held.keep));
                    check_eq("hold_last", 64'(m_axis_tlast), 64'(held.last));
                end
                if (after_last && btb_mode && exp_q.size() > 0) begin
                    check_eq("b2b_valid", 64'(m_axis_tvalid), 64'd1);
                end
                after_last = 1'b0;
                if (m_axis_tvalid && m_axis_tready) begin
                    n_out++;
                    check_eq("beat_expected", 64'(exp_q.size() != 0), 64'd1);
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        check_eq("beat_data", m_axis_tdata, e.data);
                        check_eq("beat_keep", 64'(m_axis_tkeep), 64'(e.keep));
                        check_eq("beat_last", 64'(m_axis_tlast), 64'(e.last));
                    end
                    after_last = m_axis_tlast;
                end
                stalled   = m_axis_tvalid && !m_axis_tready;
                held.data = m_axis_tdata;
                held.keep = m_axis_tkeep;
                held.last = m_axis_tlast;
            end
        end
    end

    initial begin : main
        int unsigned base;
        int n;
        repeat (2) tick();
        check_eq("rst_tdata", m_axis_tdata, 64'h0);
        check_eq("rst_tkeep", 64'(m_axis_tkeep), 64'h0);
        check_eq("rst_tlast", 64'(m_axis_tlast), 64'h0);
        check_eq("rst_state", 64'(state_dbg), 64'h0);
        do_reset("rst");

        // payload_beats == 0 must never start, even with input valid.
        enable        = 1'b1;
        payload_beats = '0;
        in_q.push_back(64'h1);
        repeat (8) tick();
        check_eq("len0_busy", 64'(busy), 64'd0);
        check_eq("len0_tvalid", 64'(m_axis_tvalid), 64'd0);
        in_q.delete();
        tick();

        // 1: reference frame, L = 8.
        push_s1();
        wait_drain("s1", 200);

        // 2: short frame with padding, then an oversized request clamped.
        payload_beats = LW'(2);
        push_frame(2);
        wait_drain("s2_short", 200);
        payload_beats = LW'(2000);
        push_frame(2000);
        wait_drain("s2_clamp", 3000);

        // 3: scenario-1 stream under random backpressure.
        do_reset("s3_rst");
        rand_ready = 1'b1;
        push_s1();
        wait_drain("s3", 400);
        rand_ready = 1'b0;

        // 4: input gaps every third cycle.
        gap_mode      = 1'b1;
        payload_beats = LW'(8);
        push_frame(8);
        wait_drain("s4", 300);
        gap_mode = 1'b0;

        // 5: three back-to-back frames from a fresh seq counter.
        do_reset("s5_rst");
        btb_mode      = 1'b1;
        payload_beats = LW'(8);
        for (int f = 0; f < 3; f++) push_frame(8);
        wait_drain("s5", 300);
        btb_mode = 1'b0;

        // 6: reset in the middle of a frame, then a clean frame.
        payload_beats = LW'(8);
        base = n_out;
        push_frame(8);
        n = 0;
        while (n_out < base + 7 && n < 200) begin
            tick();
            n++;
        end
        check_eq("s6_reached", 64'(n_out >= base + 7), 64'd1);
        do_reset("s6_rst");
        tick();
        payload_beats = LW'(3);
        push_frame(3);
        wait_drain("s6_after", 200);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/eth_frame_former_v2.md
Name: eth_frame_former_v2

Overview:
- Parametrised successor to the team's fixed 64-bit Ethernet frame former. It emits complete frames on an AXI4-Stream manager port.
- Frame layout: MAC header, custom sync/link-type word, optional sequence/length word, payload pulled from an upstream AXIS FIFO, optional zero padding to the minimum frame size, and a 2-byte trailer.
- Sits between the payload FIFO and the Ethernet MAC TX stream.

Parameters:
- MAX_PAYLOAD_BEATS, 1024: largest payload in 64-bit beats; larger requests clamp to this value.
- SEQ_EN, 1: 1 inserts the sequence/length header beat; 0 omits it.
- TRAILER_WORD, 16'h5704: value of the final 2-byte trailer.
- LEN_W, $clog2(MAX_PAYLOAD_BEATS+1): width of the length port (derived, not overridden).

Ports:
- ACLK  in  1  clock
- ARESETN  in  1  synchronous active-low reset
- enable  in  1  permits new frame starts; never aborts a frame in flight
- dest_addr  in  48  destination MAC
- src_addr  in  48  source MAC
- link_type  in  16  EtherType
- sync_word  in  16  sync marker
- payload_beats  in  LEN_W  payload length per frame, in beats
- s_axis_tdata  in  64  payload data
- s_axis_tvalid  in  1  payload valid
- s_axis_tready  out  1  payload accept
- m_axis_tdata  out  64  frame data; byte k = bits [8k+7:8k]
- m_axis_tkeep  out  8  byte enables
- m_axis_tvalid  out  1  frame valid
- m_axis_tready  in  1  downstream ready
- m_axis_tlast  out  1  last beat of frame
- seq_num  out  32  sequence number of the next frame
- busy  out  1  high from frame start until the tlast handshake
- state_dbg  out  3  current state encoding

Behaviour:
- Reset: ARESETN, synchronous, active-low; clock ACLK. On reset:
  - m_axis_tvalid, m_axis_tlast, s_axis_tready, busy = 0.
  - m_axis_tdata = 0, m_axis_tkeep = 0, seq_num = 0, state = IDLE.
  - A frame in flight is abandoned with no tlast and no further beats.
- Output register: loads only when (!m_axis_tvalid || m_axis_tready). While tvalid && !tready, tdata/tkeep/tlast hold stable.
- States are named by the next beat to load: IDLE, HDR1, SEQ, PAYLOAD, PAD, TRAILER.
- Frame start:
  - Condition: IDLE, enable, s_axis_tvalid, payload_beats != 0, and the output register free.
  - On that edge: latch all config, clamped length L, and pad count; load beat0; go to HDR1.
  - m_axis_tvalid rises the cycle after the start condition.
  - payload_beats == 0 never starts a frame.
- Header beats:
  - Beat0 = {src[15:0], dest[47:0]}, keep FF.
  - Beat1 = {sync_word, link_type, src[47:16]}, keep FF. Next state: SEQ if SEQ_EN, else PAYLOAD.
  - SEQ beat = {16'h0, L[15:0] zero-extended, seq_num}, keep FF.
- PAYLOAD:
  - s_axis_tready = output register free.
  - Each input handshake loads s_axis_tdata with keep FF.
  - A cycle with no s_axis_tvalid produces an output bubble (tvalid 0). Bubbles are legal mid-frame.
  - After L input handshakes: go to PAD if pad count > 0, else TRAILER.
  - s_axis_tready = 0 in every other state.
- Padding: MIN_BODY = 5 if SEQ_EN, else 6. Pad count = max(0, MIN_BODY - L). PAD loads zero beats with keep FF and consumes no input.
- TRAILER: loads {48'h0, TRAILER_WORD}, keep 8'h03, tlast 1; next state IDLE.
- Sequence number: seq_num increments (32-bit wrap) on the tlast handshake.
- Back-to-back frames: a new beat0 may load on the same edge as the trailer handshake, so there is no idle cycle between frames.
- busy: set on start, cleared on the tlast handshake.
- Config changes mid-frame have no effect until the next start.

Decomposition:
- Package eth_ff_pkg holds:
  - state enum (3-bit);
  - header beat builder functions;
  - MIN_BODY constants;
  - KEEP_FULL = 8'hFF and KEEP_TRAILER = 8'h03.
- Sub-module axis_out_reg: the 64+8+1 output register with load/hold rule. It is reusable by other stream blocks.

Test Plan:
1. SEQ_EN=1, L=8, dest=0A0B0C0D0E0F, src=112233445566, type=88B5, sync=A5A5, tready=1, continuous input -> 12 beats:
   - beat0 = 55660A0B0C0D0E0F, beat1 = A5A588B511223344, beat2 = 0000000800000000;
   - 8 payload beats in order;
   - trailer data = 5704, keep 03, tlast.
2. L=2, then L=2000 -> first frame: 2 input handshakes, 3 zero PAD beats, trailer (9 beats total). Second frame: clamped to 1024 payload beats, and beat2 shows 0400.
3. Random 50% m_axis_tready -> tdata/tkeep/tlast never change while tvalid && !tready; captured byte stream identical to scenario 1.
4. s_axis_tvalid gaps every third cycle during L=8 -> output bubbles only; exactly 8 payload beats; tlast on beat 12.
5. Three back-to-back frames with input always valid -> beat2 low words read 0, 1, 2; the next beat0 is valid the cycle after each tlast handshake.
6. ARESETN low for one cycle at payload beat 4 -> next cycle tvalid = 0, s_axis_tready = 0, seq_num = 0, busy = 0; the following frame starts clean with seq 0.
